uart_rx_oversample: RTL and testbench
=====================================

Name: uart_rx_oversample

Overview:
- RS-232 receive side: the companion to the team's TX block; pairs with it over the same physical line.
- Format: 8N1, LSB first, same ClkFrequency/Baud parameter set as the TX block.
- Samples the async RxD line on an oversampled tick, filters glitches and decodes start/data/stop.
- Delivers each byte as a one-cycle valid pulse; also flags framing errors and inter-packet gaps to the host logic.

Parameters:
- ClkFrequency, 25000000, system clock in Hz.
- Baud, 115200, line bit rate.
- Oversampling, 16, ticks per bit; power of 2, range 8..16.
- AccWidth, 16, baud accumulator fraction width.
- GapBits, 10, idle bit-times before RxD_idle asserts.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- RxD  in  1  async serial input, idle high.
- RxD_data  out  8  last good byte received.
- RxD_data_ready  out  1  one-cycle pulse: RxD_data updated this cycle.
- RxD_framing_error  out  1  one-cycle pulse: stop bit sampled low.
- RxD_idle  out  1  line high for at least GapBits bit-times.
- RxD_endofpacket  out  1  one-cycle pulse when RxD_idle rises after at least one byte.

Behaviour:
- Reset (asynchronous, active-low; only reset in the block):
  - outputs: RxD_data=0, RxD_data_ready=0, RxD_framing_error=0, RxD_idle=1, RxD_endofpacket=0;
  - internals: FSM=IDLE, synchroniser flops=1, filter=3, gap counter saturated, "byte seen" flag=0.
- Tick generator:
  - (AccWidth+1)-bit accumulator, increment = round(Baud*Oversampling*2^AccWidth / ClkFrequency);
  - tick = accumulator MSB; each cycle, acc <= acc[AccWidth-1:0] + inc;
  - free-running, never gated by state.
- Input conditioning:
  - 2-flop synchroniser on RxD.
  - Filter: 2-bit saturating counter updated on ticks (increments when the synchronised bit is 1, decrements when 0).
  - Filtered bit goes 0 when the counter reaches 0 and 1 when it reaches 3; otherwise it holds.
  - Pulses shorter than about 3 ticks are rejected.
- FSM (all transitions on tick only):
  - IDLE: filtered=0 -> START, clear the tick counter.
  - START: after Oversampling/2 ticks, re-check the filtered bit. If 0 -> DATA (bit index 0). If 1 -> IDLE (glitch, no outputs).
  - DATA: every Oversampling ticks, shift the filtered bit into the MSB of the shift register (LSB arrives first). After the 8th bit -> STOP.
  - STOP: after Oversampling ticks, sample:
    - 1: RxD_data <= shift register, RxD_data_ready pulses on the next clk edge, "byte seen"=1.
    - 0: RxD_framing_error pulses, RxD_data unchanged, no ready pulse.
    - Either way -> IDLE. If the line is still low, the start-edge search only resumes once filtered=1.
  - Latency: ready pulse is exactly 1 clk after the stop-bit centre tick.
- Gap detector:
  - Counter cleared whenever filtered=0 or FSM != IDLE; incremented on ticks up to GapBits*Oversampling, then saturates.
  - RxD_idle = counter saturated.
  - RxD_endofpacket pulses on the clk where RxD_idle goes 0->1 while "byte seen"=1; "byte seen" is then cleared.
- Simultaneous events: ready and framing_error are never asserted together. A new start edge seen in the same tick as leaving STOP is honoured in the next tick.
- Back-to-back frames with a single stop bit must be received with no loss.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, STOP), also usable for TX;
  - function computing the baud accumulator increment from ClkFrequency, Baud, Oversampling, AccWidth;
  - constant DATA_BITS=8.
- One sub-module, uart_baud_tick (accumulator tick generator), parameterised for reuse by TX. Filter and FSM stay in this module.

Test Plan (ClkFrequency=1600000, Baud=100000, Oversampling=16 -> tick every clk, 16 clk/bit):
- Frame 0xA5 (line: 0,1,0,1,0,0,1,0,1,1) -> exactly one RxD_data_ready pulse, RxD_data=0xA5, no framing_error; 0x00 and 0xFF likewise correct.
- Low glitch of 2 clk on idle line -> no ready, no framing_error, FSM back to IDLE, RxD_idle stays 1.
- Frame 0x3C with stop bit held low -> one RxD_framing_error pulse, RxD_data keeps previous 0xA5, no ready.
- Three back-to-back frames 0x01,0x02,0x03 at ±2% baud offset -> three ready pulses in order, data correct.
- After the last byte, line high for 160 clk -> RxD_idle rises, RxD_endofpacket one pulse; a further idle period gives no second pulse.
- rst_n asserted during bit 4 of a frame -> all outputs at reset values immediately; next full frame 0x5A received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit blocks.
//   uart_state_t : frame-level state (IDLE, START, DATA, STOP)
//   DATA_BITS    : data bits per frame (8N1)
//   baud_inc()   : increment for the fractional baud accumulator
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  // round(baud * os * 2^acc_w / clk_hz), evaluated in 64 bits to avoid overflow
  function automatic longint unsigned baud_inc(input int unsigned clk_hz,
                                               input int unsigned baud,
                                               input int unsigned os,
                                               input int unsigned acc_w);
    longint unsigned num;
    num = (64'(baud) * 64'(os)) << acc_w;
    return (num + 64'(clk_hz / 2)) / 64'(clk_hz);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running fractional accumulator producing the
// oversampled bit tick (Baud * Oversampling ticks per second on average).
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   o_tick out  one-cycle tick, accumulator carry
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned ClkFrequency = 25000000,
  parameter int unsigned Baud         = 115200,
  parameter int unsigned Oversampling = 16,
  parameter int unsigned AccWidth     = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam logic [AccWidth:0] INC =
    (AccWidth + 1)'(baud_inc(ClkFrequency, Baud, Oversampling, AccWidth));

  logic [AccWidth:0] r_acc;

  // Carry bit is dropped each cycle so it appears for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_acc <= '0;
    else        r_acc <= {1'b0, r_acc[AccWidth-1:0]} + INC;
  end

  assign o_tick = r_acc[AccWidth];

endmodule

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: 8N1 serial receiver with oversampled input filtering.
// Ports:
//   clk               in   system clock, rising edge
//   rst_n             in   asynchronous active-low reset
//   RxD               in   async serial input, idle high
//   RxD_data          out  last good byte received
//   RxD_data_ready    out  one-cycle pulse, RxD_data updated
//   RxD_framing_error out  one-cycle pulse, stop bit sampled low
//   RxD_idle          out  line high for at least GapBits bit-times
//   RxD_endofpacket   out  one-cycle pulse when RxD_idle rises after a byte
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int unsigned ClkFrequency = 25000000,
  parameter int unsigned Baud         = 115200,
  parameter int unsigned Oversampling = 16,
  parameter int unsigned AccWidth     = 16,
  parameter int unsigned GapBits      = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       RxD_framing_error,
  output logic       RxD_idle,
  output logic       RxD_endofpacket
);

  localparam int unsigned CNT_W     = $clog2(Oversampling);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(Oversampling / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(Oversampling - 1);
  localparam int unsigned GAP_MAX_I = GapBits * Oversampling;
  localparam int unsigned GAP_W     = $clog2(GAP_MAX_I + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_MAX_I);
  localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);

  logic              w_tick;
  logic [1:0]        r_sync;
  logic [1:0]        r_filt_cnt, w_filt_cnt_next;
  logic              r_filt_bit;
  uart_state_t       r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic              r_wait_high;
  logic [7:0]        r_data;
  logic              r_ready, r_ferr, r_idle, r_eop, r_byte_seen;
  logic [GAP_W-1:0]  r_gap, w_gap_next;
  logic              w_idle_next, w_eop_set;
  logic              w_cnt_clr, w_shift_en, w_ready_set, w_ferr_set;

  uart_baud_tick #(
    .ClkFrequency(ClkFrequency),
    .Baud        (Baud),
    .Oversampling(Oversampling),
    .AccWidth    (AccWidth)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .o_tick(w_tick)
  );

  // Input synchroniser and saturating glitch filter
  always_comb begin
    w_filt_cnt_next = r_filt_cnt;
    if (r_sync[1] && r_filt_cnt != 2'd3)       w_filt_cnt_next = r_filt_cnt + 2'd1;
    else if (!r_sync[1] && r_filt_cnt != 2'd0) w_filt_cnt_next = r_filt_cnt - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync     <= 2'b11;
      r_filt_cnt <= 2'd3;
      r_filt_bit <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], RxD};
      if (w_tick) begin
        r_filt_cnt <= w_filt_cnt_next;
        if (w_filt_cnt_next == 2'd3)      r_filt_bit <= 1'b1;
        else if (w_filt_cnt_next == 2'd0) r_filt_bit <= 1'b0;
      end
    end
  end

  // Frame FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_shift_en   = 1'b0;
    w_ready_set  = 1'b0;
    w_ferr_set   = 1'b0;
    if (w_tick) begin
      unique case (r_state)
        IDLE: begin
          if (!r_filt_bit && !r_wait_high) begin
            w_state_next = START;
            w_cnt_clr    = 1'b1;
          end
        end
        START: begin
          if (r_cnt == HALF_LAST) begin
            w_cnt_clr    = 1'b1;
            w_state_next = r_filt_bit ? IDLE : DATA;
          end
        end
        DATA: begin
          if (r_cnt == FULL_LAST) begin
            w_cnt_clr  = 1'b1;
            w_shift_en = 1'b1;
            if (r_bit_idx == LAST_BIT) w_state_next = STOP;
          end
        end
        STOP: begin
          if (r_cnt == FULL_LAST) begin
            w_cnt_clr    = 1'b1;
            w_state_next = IDLE;
            if (r_filt_bit) w_ready_set = 1'b1;
            else            w_ferr_set  = 1'b1;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Datapath; r_wait_high blocks a new start search after a low stop bit
  // until the line has been seen high again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_wait_high <= 1'b0;
      r_data      <= '0;
      r_ready     <= 1'b0;
      r_ferr      <= 1'b0;
    end else begin
      if (w_tick) begin
        if (w_cnt_clr) r_cnt <= '0;
        else           r_cnt <= r_cnt + CNT_W'(1);
      end
      if (r_state == START)  r_bit_idx <= '0;
      else if (w_shift_en)   r_bit_idx <= r_bit_idx + 3'd1;
      if (w_shift_en) r_shift <= {r_filt_bit, r_shift[7:1]};
      if (w_ferr_set)                r_wait_high <= 1'b1;
      else if (w_tick && r_filt_bit) r_wait_high <= 1'b0;
      if (w_ready_set) r_data <= r_shift;
      r_ready <= w_ready_set;
      r_ferr  <= w_ferr_set;
    end
  end

  // Gap detector; idle/eop registered from the next count so they rise together
  always_comb begin
    w_gap_next = r_gap;
    if (!r_filt_bit || r_state != IDLE)   w_gap_next = '0;
    else if (w_tick && r_gap != GAP_MAX)  w_gap_next = r_gap + GAP_W'(1);
    w_idle_next = (w_gap_next == GAP_MAX);
    w_eop_set   = w_idle_next && !r_idle && r_byte_seen;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap       <= GAP_MAX;
      r_idle      <= 1'b1;
      r_eop       <= 1'b0;
      r_byte_seen <= 1'b0;
    end else begin
      r_gap  <= w_gap_next;
      r_idle <= w_idle_next;
      r_eop  <= w_eop_set;
      if (w_ready_set)    r_byte_seen <= 1'b1;
      else if (w_eop_set) r_byte_seen <= 1'b0;
    end
  end

  assign RxD_data          = r_data;
  assign RxD_data_ready    = r_ready;
  assign RxD_framing_error = r_ferr;
  assign RxD_idle          = r_idle;
  assign RxD_endofpacket   = r_eop;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench: 10-unit clock, 16 clk per nominal bit (160 units).
module tb_uart_rx_oversample;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RxD = 1'b1;
  logic [7:0] RxD_data;
  logic       RxD_data_ready, RxD_framing_error, RxD_idle, RxD_endofpacket;

  int unsigned passed = 0;
  int unsigned total  = 0;

  int unsigned n_ready = 0, n_ferr = 0, n_eop = 0, n_both = 0, n_idle_low = 0;
  logic [7:0]  rx_q[$];

  uart_rx_oversample #(
    .ClkFrequency(1600000),
    .Baud        (100000),
    .Oversampling(16),
    .AccWidth    (16),
    .GapBits     (10)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .RxD              (RxD),
    .RxD_data         (RxD_data),
    .RxD_data_ready   (RxD_data_ready),
    .RxD_framing_error(RxD_framing_error),
    .RxD_idle         (RxD_idle),
    .RxD_endofpacket  (RxD_endofpacket)
  );

  always #5 clk = ~clk;

  // Output event monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (RxD_data_ready) begin
      n_ready++;
      rx_q.push_back(RxD_data);
    end
    if (RxD_framing_error) n_ferr++;
    if (RxD_data_ready && RxD_framing_error) n_both++;
    if (RxD_endofpacket) n_eop++;
    if (!RxD_idle) n_idle_low++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int unsigned bit_t);
    RxD = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      #(bit_t);
    end
    RxD = stop_bit;
    #(bit_t);
    RxD = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    RxD   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (RxD_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", RxD_data); else passed++;
    total++; if (RxD_data_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", RxD_data_ready); else passed++;
    total++; if (RxD_framing_error !== 1'b0) $display("FAIL reset_ferr: got %b expected 0", RxD_framing_error); else passed++;
    total++; if (RxD_idle !== 1'b1) $display("FAIL reset_idle: got %b expected 1", RxD_idle); else passed++;
    total++; if (RxD_endofpacket !== 1'b0) $display("FAIL reset_eop: got %b expected 0", RxD_endofpacket); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_frames();
    logic [7:0] bytes [4];
    int unsigned r0, f0;
    bytes = '{8'hA5, 8'h00, 8'hFF, 8'hA5};
    for (int k = 0; k < 4; k++) begin
      r0 = n_ready;
      f0 = n_ferr;
      send_frame(bytes[k], 1'b1, 160);
      repeat (30) @(negedge clk);
      total++; if (n_ready - r0 !== 1) $display("FAIL frame_ready_count[%0d]: got %0d expected 1", k, n_ready - r0); else passed++;
      total++; if (n_ferr - f0 !== 0) $display("FAIL frame_ferr_count[%0d]: got %0d expected 0", k, n_ferr - f0); else passed++;
      total++; if (RxD_data !== bytes[k]) $display("FAIL frame_data[%0d]: got %h expected %h", k, RxD_data, bytes[k]); else passed++;
      repeat (20) @(negedge clk);
    end
  endtask

  task automatic test_glitch();
    int unsigned r0, f0, i0;
    repeat (200) @(negedge clk);
    total++; if (RxD_idle !== 1'b1) $display("FAIL glitch_pre_idle: got %b expected 1", RxD_idle); else passed++;
    r0 = n_ready; f0 = n_ferr; i0 = n_idle_low;
    @(negedge clk);
    RxD = 1'b0;
    #20;
    RxD = 1'b1;
    repeat (200) @(negedge clk);
    total++; if (n_ready - r0 !== 0) $display("FAIL glitch_ready: got %0d expected 0", n_ready - r0); else passed++;
    total++; if (n_ferr - f0 !== 0) $display("FAIL glitch_ferr: got %0d expected 0", n_ferr - f0); else passed++;
    total++; if (n_idle_low - i0 !== 0) $display("FAIL glitch_idle_drop: got %0d low cycles expected 0", n_idle_low - i0); else passed++;
  endtask

  task automatic test_framing();
    int unsigned r0, f0;
    r0 = n_ready; f0 = n_ferr;
    send_frame(8'h3C, 1'b0, 160);
    repeat (30) @(negedge clk);
    total++; if (n_ferr - f0 !== 1) $display("FAIL framing_ferr: got %0d expected 1", n_ferr - f0); else passed++;
    total++; if (n_ready - r0 !== 0) $display("FAIL framing_ready: got %0d expected 0", n_ready - r0); else passed++;
    total++; if (RxD_data !== 8'hA5) $display("FAIL framing_data_hold: got %h expected a5", RxD_data); else passed++;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_back_to_back(input int unsigned bit_t);
    int unsigned r0, q0;
    logic [7:0] got;
    r0 = n_ready;
    q0 = rx_q.size();
    for (int k = 1; k <= 3; k++) send_frame(8'(k), 1'b1, bit_t);
    repeat (30) @(negedge clk);
    total++; if (n_ready - r0 !== 3) $display("FAIL b2b_count[%0d]: got %0d expected 3", bit_t, n_ready - r0); else passed++;
    for (int k = 0; k < 3; k++) begin
      got = (rx_q.size() > q0 + k) ? rx_q[q0 + k] : 8'hxx;
      total++; if (got !== 8'(k + 1)) $display("FAIL b2b_data[%0d][%0d]: got %h expected %h", bit_t, k, got, 8'(k + 1)); else passed++;
    end
    total++; if (RxD_idle !== 1'b0) $display("FAIL b2b_busy_idle[%0d]: got %b expected 0", bit_t, RxD_idle); else passed++;
  endtask

  task automatic test_eop();
    int unsigned e0, e1, waited;
    e0 = n_eop;
    waited = 0;
    while (!RxD_idle && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    total++; if (RxD_idle !== 1'b1) $display("FAIL eop_idle_rise: got %b expected 1 within 400 clk", RxD_idle); else passed++;
    repeat (5) @(negedge clk);
    total++; if (n_eop - e0 !== 1) $display("FAIL eop_pulse: got %0d expected 1", n_eop - e0); else passed++;
    e1 = n_eop;
    repeat (400) @(negedge clk);
    total++; if (n_eop - e1 !== 0) $display("FAIL eop_second: got %0d expected 0", n_eop - e1); else passed++;
    total++; if (RxD_idle !== 1'b1) $display("FAIL eop_idle_hold: got %b expected 1", RxD_idle); else passed++;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    int unsigned r0;
    b = 8'h5A;
    RxD = 1'b0;
    #160;
    for (int i = 0; i < 4; i++) begin
      RxD = b[i];
      #160;
    end
    RxD = b[4];
    #80;
    total++; if (RxD_idle !== 1'b0) $display("FAIL midframe_busy: got %b expected 0", RxD_idle); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (RxD_data !== 8'h00) $display("FAIL midreset_data: got %h expected 00", RxD_data); else passed++;
    total++; if (RxD_data_ready !== 1'b0) $display("FAIL midreset_ready: got %b expected 0", RxD_data_ready); else passed++;
    total++; if (RxD_framing_error !== 1'b0) $display("FAIL midreset_ferr: got %b expected 0", RxD_framing_error); else passed++;
    total++; if (RxD_idle !== 1'b1) $display("FAIL midreset_idle: got %b expected 1", RxD_idle); else passed++;
    total++; if (RxD_endofpacket !== 1'b0) $display("FAIL midreset_eop: got %b expected 0", RxD_endofpacket); else passed++;
    #79;
    RxD = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    r0 = n_ready;
    send_frame(8'h5A, 1'b1, 160);
    repeat (30) @(negedge clk);
    total++; if (n_ready - r0 !== 1) $display("FAIL post_reset_ready: got %0d expected 1", n_ready - r0); else passed++;
    total++; if (RxD_data !== 8'h5A) $display("FAIL post_reset_data: got %h expected 5a", RxD_data); else passed++;
  endtask

  initial begin
    test_reset();
    test_frames();
    test_glitch();
    test_framing();
    test_back_to_back(157);
    repeat (20) @(negedge clk);
    test_back_to_back(163);
    test_eop();
    test_reset_midframe();
    total++; if (n_both !== 0) $display("FAIL ready_with_ferr: got %0d cycles expected 0", n_both); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
